// File: rtl/riscv_sim_ctrl.sv
// riscv_sim_ctrl: memory-mapped console/exit controller for the picorv32
// native memory bus. A 16-byte window holds TXDATA, STATUS, EXIT and CYCLES.
// Console bytes queue in a small FIFO drained over a tx_valid/tx_ready stream.
// EXIT latches a sticky done flag with a code. An optional cycle timeout
// forces done with code 8'hFF.
// Optional feature macro: SIM_CONSOLE_PRINT_EN (simulation-only console echo
// and $finish on done). Leave it undefined for synthesis.

module riscv_sim_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h9000_0000,
    parameter int          FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        done,
    output logic [7:0]  exit_code
);

    localparam int          PTR_W        = $clog2(FIFO_DEPTH);
    localparam int          CNT_W        = PTR_W + 1;
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_EXIT   = 2'd2;
    localparam logic [1:0] REG_CYCLES = 2'd3;

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t state;
    state_t state_next;

    logic             in_window;
    logic             is_write;
    logic [1:0]       reg_sel;
    logic             push_req;
    logic             accept;
    logic             push;
    logic             pop;
    logic             timeout_hit;
    logic [31:0]      rd_value;
    logic [31:0]      cycle_cnt;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_level;

    // Address bits [1:0] and write data above the byte lane carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

    assign in_window   = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign is_write    = |mem_wstrb;
    assign reg_sel     = mem_addr[3:2];
    assign push_req    = is_write && mem_wstrb[0] && (reg_sel == REG_TXDATA);

    assign fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty  = (fifo_count == '0);
    assign fifo_level  = 8'(fifo_count);
    assign tx_valid    = !fifo_empty;
    assign tx_data     = fifo_empty ? 8'h00 : fifo_mem[head];

    assign push        = accept && push_req;
    assign pop         = !fifo_empty && tx_ready;
    assign timeout_hit = TIMEOUT_EN && (cycle_cnt == TIMEOUT_LAST);

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accept an in-window request from IDLE unless it is a push into a full FIFO; ACK forces a gap cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (in_window && !(push_req && fifo_full)) begin
                    accept     = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read data mux for the register currently addressed.
    always_comb begin
        rd_value = 32'h0;
        case (reg_sel)
            REG_TXDATA: rd_value = 32'h0;
            REG_STATUS: rd_value = {16'h0, fifo_level, 6'b0, fifo_empty, fifo_full};
            REG_EXIT:   rd_value = {23'h0, done, exit_code};
            REG_CYCLES: rd_value = cycle_cnt;
            default:    rd_value = 32'h0;
        endcase
    end

    // Registered bus response: one-cycle ready pulse with read data, zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
        end else begin
            mem_ready <= accept;
            mem_rdata <= (accept && !is_write) ? rd_value : 32'h0;
        end
    end

    // FIFO storage; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail] <= mem_wdata[7:0];
        end
    end

    // FIFO pointers and occupancy; full is judged on the count at cycle start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Free-running cycle counter since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Sticky done flag; an EXIT write beats a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            exit_code <= 8'h00;
        end else if (!done) begin
            if (accept && is_write && (reg_sel == REG_EXIT)) begin
                done      <= 1'b1;
                exit_code <= mem_wdata[7:0];
            end else if (timeout_hit) begin
                done      <= 1'b1;
                exit_code <= 8'hFF;
            end
        end
    end

`ifdef SIM_CONSOLE_PRINT_EN
    logic done_q;
    logic finish_pending;

    // Echo popped bytes, announce done once, and finish once no transaction is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q         <= 1'b0;
            finish_pending <= 1'b0;
        end else begin
            done_q <= done;
            if (pop) begin
                $write("%c", tx_data);
            end
            if (done && !done_q) begin
                $write("\n--- done (code %0d) ---\n", exit_code);
                finish_pending <= 1'b1;
            end
            if (finish_pending && (state == IDLE) && !accept) begin
                $finish;
            end
        end
    end
`endif

endmodule
